// File: rtl/lamp_ctrl_pkg.sv
// Shared constants and helpers for the multi-way lamp controller.
package lamp_ctrl_pkg;

    localparam logic MODE_PUSH   = 1'b0;
    localparam logic MODE_ROCKER = 1'b1;

    // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lamp_sw_debounce.sv
// One switch channel: 2-flop synchroniser, debounce counter and edge decode.
// evt is a registered 1-cycle pulse on an accepted level change, filtered by mode.
module lamp_sw_debounce
    import lamp_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mode,
    input  logic s_raw,
    output logic evt
);

    localparam int CW_RAW = clog2(DEB_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync;
    logic          r_deb;
    logic          r_deb_d;
    logic [CW-1:0] r_cnt;
    logic          r_evt;

    // Bring the raw level into the clock domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync  <= 1'b0;
        end else begin
            r_sync1 <= s_raw;
            r_sync  <= r_sync1;
        end
    end

    // Accept a new level only after it differs for DEB_CYCLES consecutive cycles;
    // any return to the debounced level restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_deb <= r_sync;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Edge decode: rising only for pushbuttons, either edge for rockers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_deb_d <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_deb_d <= r_deb;
            r_evt   <= (mode == MODE_ROCKER) ? (r_deb ^ r_deb_d) : (r_deb & ~r_deb_d);
        end
    end

    assign evt = r_evt;

endmodule

// File: rtl/lamp_ctrl_multi.sv
// N-way lamp controller: each accepted switch event toggles F; an odd number of
// simultaneous events toggles, an even number cancels. Optional auto-off timer.
module lamp_ctrl_multi
    import lamp_ctrl_pkg::*;
#(
    parameter int N_SW       = 3,
    parameter int DEB_CYCLES = 16,
    parameter int TMO_W      = 16,
    parameter int TIMEOUT    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [N_SW-1:0] S,
    output logic            F,
    output logic [N_SW-1:0] evt,
    output logic            expired
);

    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TIMEOUT - 1) : '0;

    logic [N_SW-1:0]  w_evt;
    logic             w_tog;
    logic             w_any;
    logic             r_f;
    logic             r_exp;
    logic [TMO_W-1:0] r_tmr;

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_ch
            lamp_sw_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk   (clk),
                .rst_n (rst_n),
                .mode  (mode),
                .s_raw (S[gi]),
                .evt   (w_evt[gi])
            );
        end
    endgenerate

    assign w_tog = ^w_evt;
    assign w_any = |w_evt;

    // Lamp state and idle timer. Any event clears the timer and takes priority
    // over expiry, so expiry only fires on a truly idle lamp.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f   <= 1'b0;
            r_exp <= 1'b0;
            r_tmr <= '0;
        end else begin
            r_exp <= 1'b0;
            if (!r_f || w_any) begin
                r_tmr <= '0;
                if (w_tog) r_f <= ~r_f;
            end else if (TMO_EN && (r_tmr == TMO_LAST)) begin
                r_f   <= 1'b0;
                r_exp <= 1'b1;
                r_tmr <= '0;
            end else if (TMO_EN) begin
                r_tmr <= r_tmr + 1'b1;
            end else begin
                r_tmr <= '0;
            end
        end
    end

    assign F       = r_f;
    assign evt     = w_evt;
    assign expired = r_exp;

endmodule

// File: tb/tb_lamp_ctrl_multi.sv
// Scoreboard bench: stimulus pushes (cycle, signal, value) expectations,
// a negedge monitor pops and compares them when their cycle comes up.
module tb_lamp_ctrl_multi;

    localparam int N   = 3;
    localparam int DEB = 4;
    localparam int TMO = 100;
    localparam int TW  = 16;

    localparam int K_EVT = 0;
    localparam int K_F   = 1;
    localparam int K_EXP = 2;

    logic         clk = 1'b0;
    logic         rst_n, rst_nb, mode;
    logic [N-1:0] S, S_b;
    logic         F, F_b, expired, expired_b;
    logic [N-1:0] evt, evt_b;

    lamp_ctrl_multi #(.N_SW(N), .DEB_CYCLES(DEB), .TMO_W(TW), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .S(S),
        .F(F), .evt(evt), .expired(expired)
    );

    // Auto-off disabled build
    lamp_ctrl_multi #(.N_SW(N), .DEB_CYCLES(DEB), .TMO_W(TW), .TIMEOUT(0)) u_dut_nt (
        .clk(clk), .rst_n(rst_nb), .mode(mode), .S(S_b),
        .F(F_b), .evt(evt_b), .expired(expired_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        int         inst;
        int         kind;
        logic [2:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    task automatic expect_at(input int c, input int inst, input int kind,
                             input logic [2:0] v, input string tag);
        exp_t e;
        e.cyc = c; e.inst = inst; e.kind = kind; e.val = v; e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due this cycle
    logic [2:0] mon_obs;
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].kind)
                    K_EVT:   mon_obs = (sb[i].inst != 0) ? evt_b : evt;
                    K_F:     mon_obs = {2'b00, (sb[i].inst != 0) ? F_b : F};
                    default: mon_obs = {2'b00, (sb[i].inst != 0) ? expired_b : expired};
                endcase
                chk($sformatf("%s@%0d", sb[i].tag, cyc), 32'(mon_obs), 32'(sb[i].val));
                sb.delete(i);
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Hold reset for three edges with the given switch levels, check cleared outputs.
    task automatic do_reset(input logic [2:0] s0);
        @(negedge clk);
        rst_n = 1'b0;
        S     = s0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_F", 32'(F), 0);
        chk("rst_evt", 32'(evt), 0);
        chk("rst_expired", 32'(expired), 0);
        rst_n = 1'b1;
    endtask

    // TIMEOUT=0 instance: lamp must stay on indefinitely
    initial begin : nt_proc
        int nb;
        rst_nb = 1'b0;
        S_b    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_nb = 1'b1;
        nb = cyc;
        S_b = 3'b001;
        expect_at(nb + 7, 1, K_EVT, 3'b001, "nt_evt");
        expect_at(nb + 8, 1, K_F, 3'd1, "nt_F_on");
        expect_at(nb + 108, 1, K_EXP, 3'd0, "nt_no_expire");
        for (int k = 1; k <= 10; k++)
            expect_at(nb + 8 + 1000 * k, 1, K_F, 3'd1, "nt_F_hold");
    end

    initial begin : main
        int n, a, b;
        rst_n = 1'b0;
        S     = '0;
        mode  = 1'b0;

        // 1: switches held high through reset -> all three debounce, odd count -> F on
        do_reset(3'b111);
        n = cyc;
        expect_at(n + 6, 0, K_EVT, 3'b000, "t1_evt_early");
        expect_at(n + 7, 0, K_EVT, 3'b111, "t1_evt");
        expect_at(n + 7, 0, K_F, 3'd0, "t1_F_pre");
        expect_at(n + 8, 0, K_EVT, 3'b000, "t1_evt_pulse");
        expect_at(n + 8, 0, K_F, 3'd1, "t1_F");
        step(20);

        // 2: pushbutton rise toggles, fall ignored; then idle expiry after 100 cycles
        mode = 1'b0;
        do_reset(3'b000);
        n = cyc;
        S[0] = 1'b1;
        expect_at(n + 7, 0, K_EVT, 3'b001, "t2_evt");
        expect_at(n + 8, 0, K_EVT, 3'b000, "t2_evt_pulse");
        expect_at(n + 8, 0, K_F, 3'd1, "t2_F");
        step(20);
        S[0] = 1'b0;
        expect_at(n + 27, 0, K_EVT, 3'b000, "t2_fall_evt");
        expect_at(n + 28, 0, K_EVT, 3'b000, "t2_fall_evt2");
        expect_at(n + 28, 0, K_F, 3'd1, "t2_fall_F");
        expect_at(n + 107, 0, K_F, 3'd1, "t6_F_last");
        expect_at(n + 107, 0, K_EXP, 3'd0, "t6_exp_pre");
        expect_at(n + 108, 0, K_F, 3'd0, "t6_F_off");
        expect_at(n + 108, 0, K_EXP, 3'd1, "t6_exp");
        expect_at(n + 109, 0, K_EXP, 3'd0, "t6_exp_pulse");
        step(95);

        // 3: short pulse and bounce train on S[1] are rejected, then a solid press accepted
        mode = 1'b0;
        do_reset(3'b000);
        n = cyc;
        S[1] = 1'b1;
        step(3);
        S[1] = 1'b0;
        step(4);
        repeat (6) begin
            S[1] = 1'b1;
            step(2);
            S[1] = 1'b0;
            step(2);
        end
        a = cyc;
        S[1] = 1'b1;
        for (int c = cyc + 1; c <= a + 6; c++) begin
            expect_at(c, 0, K_EVT, 3'b000, "t3_no_evt");
            expect_at(c, 0, K_F, 3'd0, "t3_F_off");
        end
        expect_at(a + 7, 0, K_EVT, 3'b010, "t3_solid_evt");
        expect_at(a + 8, 0, K_F, 3'd1, "t3_solid_F");
        step(20);

        // 4: rocker multi-way switching, F follows XOR of levels
        mode = 1'b1;
        do_reset(3'b000);
        n = cyc;
        S[0] = 1'b1;
        expect_at(n + 7, 0, K_EVT, 3'b001, "t4_evt0");
        expect_at(n + 8, 0, K_F, 3'd1, "t4_F0");
        step(20);
        S[1] = 1'b1;
        expect_at(n + 27, 0, K_EVT, 3'b010, "t4_evt1");
        expect_at(n + 28, 0, K_F, 3'd0, "t4_F1");
        step(20);
        S[2] = 1'b1;
        expect_at(n + 47, 0, K_EVT, 3'b100, "t4_evt2");
        expect_at(n + 48, 0, K_F, 3'd1, "t4_F2");
        step(20);
        S[1] = 1'b0;
        expect_at(n + 67, 0, K_EVT, 3'b010, "t4_evt1_fall");
        expect_at(n + 68, 0, K_F, 3'd0, "t4_F1_fall");
        step(20);

        // 5: two simultaneous events cancel, but restart the idle timer
        mode = 1'b0;
        do_reset(3'b000);
        a = cyc;
        S[2] = 1'b1;
        expect_at(a + 8, 0, K_F, 3'd1, "t5_F_on");
        step(30);
        n = cyc;
        S[0] = 1'b1;
        S[1] = 1'b1;
        expect_at(n + 7, 0, K_EVT, 3'b011, "t5_evt_pair");
        expect_at(n + 8, 0, K_F, 3'd1, "t5_F_same");
        expect_at(n + 107, 0, K_F, 3'd1, "t5_tmr_restart");
        expect_at(n + 108, 0, K_F, 3'd0, "t5_F_expire");
        expect_at(n + 108, 0, K_EXP, 3'd1, "t5_exp");
        step(115);

        // 6b: event landing in the expiry cycle wins, no expired pulse
        mode = 1'b0;
        do_reset(3'b000);
        a = cyc;
        S[0] = 1'b1;
        expect_at(a + 8, 0, K_F, 3'd1, "t6b_F_on");
        step(100);
        S[1] = 1'b1;
        expect_at(a + 107, 0, K_EVT, 3'b010, "t6b_evt");
        expect_at(a + 107, 0, K_F, 3'd1, "t6b_F_pre");
        expect_at(a + 108, 0, K_F, 3'd0, "t6b_F_tog");
        expect_at(a + 108, 0, K_EXP, 3'd0, "t6b_no_exp");
        expect_at(a + 109, 0, K_EXP, 3'd0, "t6b_no_exp2");
        expect_at(a + 208, 0, K_F, 3'd0, "t6b_F_stay");
        step(115);

        // 6c: rocker after expiry, next level change turns the lamp back on
        mode = 1'b1;
        do_reset(3'b000);
        a = cyc;
        S[0] = 1'b1;
        expect_at(a + 8, 0, K_F, 3'd1, "t6c_F_on");
        expect_at(a + 108, 0, K_EXP, 3'd1, "t6c_exp");
        step(110);
        b = cyc;
        S[0] = 1'b0;
        expect_at(b + 7, 0, K_EVT, 3'b001, "t6c_evt");
        expect_at(b + 8, 0, K_F, 3'd1, "t6c_F_back");
        step(20);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20000 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
